div_dispatch: RTL

- Front-end stage placed directly upstream of restoring_div.
- Accepts division requests on a valid/ready stream and buffers them in a small FIFO.
- Issues one request at a time to the divider using a one-cycle start/valid_in pulse, waits for done, captures quotient and remainder, then returns them on a valid/ready result port.
- Watchdog detects a divider that never completes.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_req_fifo.sv | 54 +++++
 rtl/div_dispatch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider dispatch front-end.
package div_pkg;

    localparam int DIV_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } div_state_t;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO holding {dividend, divisor} pairs ahead of the divider.
// The extra pointer bit distinguishes full from empty when indices match.
module div_req_fifo
    import div_pkg::*;
#(
    parameter int DW    = 2 * DIV_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/div_dispatch.sv
// Front-end that queues division requests, issues them one at a time to a
// restoring divider, guards each with a watchdog and returns results in order.
// Optional macro DIV_ZERO_BYPASS_EN: zero divisors are answered locally
// (Q = all-ones, R = dividend, error) without starting the divider.
module div_dispatch
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_error,
    output logic             div_start,
    output logic             div_valid_in,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_done,
    output logic             busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    div_state_t         r_state;
    div_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_err;
    logic [WD_W-1:0]    r_wdog;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_bypass;
    logic               w_timeout;

    div_req_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid && req_ready),
        .i_data  ({req_dividend, req_divisor}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_a = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b = w_head[WIDTH-1:0];

    // Ready is held low while reset is asserted so every output reads 0.
    assign req_ready     = rst && !w_full;
    assign busy          = (r_state != IDLE) || !w_empty;
    assign div_dividend  = r_opa;
    assign div_divisor   = r_opb;
    assign rsp_quotient  = r_q;
    assign rsp_remainder = r_r;
    assign rsp_error     = r_err;
    assign w_timeout     = (r_wdog == WD_W'(TIMEOUT - 1));

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = (w_head_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state and strobe decode; ARM ignores div_done to mask a stale pulse.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        div_start    = 1'b0;
        div_valid_in = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_bypass ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start    = 1'b1;
                div_valid_in = 1'b1;
                w_state_nxt  = ARM;
            end
            ARM: w_state_nxt = WAIT;
            WAIT: begin
                if (div_done || w_timeout) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, watchdog and result capture; done wins over timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opa  <= '0;
            r_opb  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else begin
            if (w_pop) begin
                r_opa  <= w_head_a;
                r_opb  <= w_head_b;
                r_wdog <= '0;
                if (w_bypass) begin
                    r_q   <= '1;
                    r_r   <= w_head_a;
                    r_err <= 1'b1;
                end
            end
            if (r_state == WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
                if (div_done) begin
                    r_q   <= div_quotient;
                    r_r   <= div_remainder;
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_q   <= '1;
                    r_r   <= '0;
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
